// File: rtl/vec3_pair_join_if.sv
// Bundle of the two upstream show-ahead FIFO read ports and the downstream
// paired read port; the slave modport is the join, the master modport is its environment.
interface vec3_pair_join_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ARRAY_SIZE = 3
);
    // Each vector packs ARRAY_SIZE two's-complement components, component 0 in the low bits.
    logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] a_din;
    logic                                  a_empty;
    logic                                  a_rd_en;
    logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] b_din;
    logic                                  b_empty;
    logic                                  b_rd_en;
    logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] x;
    logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] y;
    logic                                  out_empty;
    logic                                  out_rd_en;
    logic [15:0]                           pair_count;

    modport slave (
        input  a_din,
        input  a_empty,
        output a_rd_en,
        input  b_din,
        input  b_empty,
        output b_rd_en,
        output x,
        output y,
        output out_empty,
        input  out_rd_en,
        output pair_count
    );

    modport master (
        output a_din,
        output a_empty,
        input  a_rd_en,
        output b_din,
        output b_empty,
        input  b_rd_en,
        input  x,
        input  y,
        input  out_empty,
        output out_rd_en,
        input  pair_count
    );
endinterface

// File: rtl/vec3_pair_join.sv
// Joins two show-ahead vec3 FIFO streams into a paired show-ahead stream
// through a two-entry pair buffer, popping both upstreams together or not at all.
module vec3_pair_join #(
    parameter int DATA_WIDTH = 32,
    parameter int ARRAY_SIZE = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    vec3_pair_join_if.slave        bus
);
    typedef logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] vec_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    vec_t        r_entry_a [2];
    vec_t        r_entry_b [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [15:0] r_pair_count;
    logic        w_pop;
    logic        w_load;

    // A pop frees a slot in the same cycle, so a full buffer can still accept a pair.
    assign w_pop  = bus.out_rd_en & (r_state != S_EMPTY);
    assign w_load = reset & ~bus.a_empty & ~bus.b_empty & ((r_state != S_FULL) | w_pop);

    assign bus.a_rd_en    = w_load;
    assign bus.b_rd_en    = w_load;
    assign bus.x          = r_entry_a[r_rd_ptr];
    assign bus.y          = r_entry_b[r_rd_ptr];
    assign bus.out_empty  = (r_state == S_EMPTY);
    assign bus.pair_count = r_pair_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_EMPTY: begin
                if (w_load) begin
                    w_next_state = S_ONE;
                end
            end
            S_ONE: begin
                if (w_load && !w_pop) begin
                    w_next_state = S_FULL;
                end else if (w_pop && !w_load) begin
                    w_next_state = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_pop && !w_load) begin
                    w_next_state = S_ONE;
                end
            end
            default: begin
                w_next_state = S_EMPTY;
            end
        endcase
    end

    // Entries are cleared on reset so the outputs read zero while empty after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                r_entry_a[i] <= '0;
                r_entry_b[i] <= '0;
            end
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_pair_count <= 16'd0;
        end else begin
            if (w_load) begin
                r_entry_a[r_wr_ptr] <= bus.a_din;
                r_entry_b[r_wr_ptr] <= bus.b_din;
                r_wr_ptr            <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr     <= ~r_rd_ptr;
                r_pair_count <= r_pair_count + 16'd1;
            end
        end
    end
endmodule
